// File: rtl/bcd_timer_ctrl.sv
// bcd_timer_ctrl: start/pause/clear sequencer for a two-digit BCD counter with prescaled ticks
// and terminal-count detection against a latched, clamped BCD limit.
module bcd_timer_ctrl #(
    parameter int PRESCALE   = 4,
    parameter int PRESCALE_W = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    input  logic [3:0] limit_tens,
    input  logic [3:0] limit_ones,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       tick,
    output logic       running,
    output logic       done
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
    localparam logic [PRESCALE_W-1:0] PMAX = PRESCALE_W'(PRESCALE - 1);

    state_t                state, state_n;
    logic [PRESCALE_W-1:0] pre, pre_n;
    logic [3:0]            tens_n, ones_n, lim_t, lim_o, lim_t_n, lim_o_n;
    logic [3:0]            clamp_t, clamp_o, inc_t, inc_o;
    logic                  done_n, load;

    assign clamp_t = limit_tens > 4'd9 ? 4'd9 : limit_tens;
    assign clamp_o = limit_ones > 4'd9 ? 4'd9 : limit_ones;
    assign inc_o   = ones == 4'd9 ? 4'd0 : ones + 4'd1;
    assign inc_t   = ones != 4'd9 ? tens : tens == 4'd9 ? 4'd0 : tens + 4'd1;
    assign tick    = state == RUN && pre == PMAX && !pause && !clear;
    assign running = state == RUN;
    assign load    = (state == IDLE || state == DONE) && start && !pause;

    always_comb begin
        state_n = state;
        pre_n   = pre;
        tens_n  = tens;
        ones_n  = ones;
        lim_t_n = lim_t;
        lim_o_n = lim_o;
        done_n  = 1'b0;
        if (clear) begin
            state_n = IDLE;
            pre_n   = '0;
            tens_n  = 4'd0;
            ones_n  = 4'd0;
        end else if (load) begin
            pre_n   = '0;
            tens_n  = 4'd0;
            ones_n  = 4'd0;
            lim_t_n = clamp_t;
            lim_o_n = clamp_o;
            done_n  = clamp_t == 4'd0 && clamp_o == 4'd0;
            state_n = done_n ? DONE : RUN;
        end else if (state == RUN && !pause) begin
            pre_n = tick ? '0 : pre + 1'b1;
            if (tick) begin
                tens_n  = inc_t;
                ones_n  = inc_o;
                done_n  = inc_t == lim_t && inc_o == lim_o;
                state_n = done_n ? DONE : RUN;
            end
        end else if (state == RUN) begin
            state_n = PAUSE;
        end else if (state == PAUSE && start && !pause) begin
            state_n = RUN;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            pre   <= '0;
            tens  <= 4'd0;
            ones  <= 4'd0;
            lim_t <= 4'd0;
            lim_o <= 4'd0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            pre   <= pre_n;
            tens  <= tens_n;
            ones  <= ones_n;
            lim_t <= lim_t_n;
            lim_o <= lim_o_n;
            done  <= done_n;
        end
    end
endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// tb_bcd_timer_ctrl: directed checks of bcd_timer_ctrl with PRESCALE=4.
module tb_bcd_timer_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0, pause = 1'b0, clear = 1'b0;
    logic [3:0] limit_tens = 4'd0, limit_ones = 4'd0;
    logic [3:0] tens, ones;
    logic       tick, running, done;
    int         checks = 0, errors = 0;

    bcd_timer_ctrl #(.PRESCALE(4), .PRESCALE_W(3)) dut (
        .clk(clk), .reset(reset), .start(start), .pause(pause), .clear(clear),
        .limit_tens(limit_tens), .limit_ones(limit_ones),
        .tens(tens), .ones(ones), .tick(tick), .running(running), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tk();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] bcd(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    initial begin
        #2;
        check("rst_count", {tens, ones}, 8'h00);
        check("rst_running", running, 0);
        check("rst_done", done, 0);
        check("rst_tick", tick, 0);
        #10 reset = 1'b1;
        tk();
        check("idle_running", running, 0);

        // limit 12: full cascade through 09 -> 10
        limit_tens = 4'd1; limit_ones = 4'd2; start = 1'b1;
        tk();
        start = 1'b0;
        check("t2_running", running, 1);
        for (int c = 1; c <= 48; c++) begin
            check("t2_tick", tick, (c % 4) == 0);
            check("t2_count", {tens, ones}, bcd((c - 1) / 4));
            check("t2_done_low", done, 0);
            tk();
        end
        check("t2_done", done, 1);
        check("t2_final", {tens, ones}, 8'h12);
        check("t2_stop", running, 0);
        tk();
        check("t2_done_pulse", done, 0);
        check("t2_hold", {tens, ones}, 8'h12);
        check("t2_no_tick", tick, 0);

        // limit 05 with pause at count 02, prescaler at 2
        limit_tens = 4'd0; limit_ones = 4'd5; start = 1'b1;
        tk();
        start = 1'b0;
        repeat (10) tk();
        check("t3_pre_pause", {tens, ones}, 8'h02);
        pause = 1'b1;
        check("t3_pause_tick", tick, 0);
        tk();
        for (int i = 0; i < 10; i++) begin
            start = (i == 4);
            check("t3_frozen", {tens, ones}, 8'h02);
            check("t3_paused", running, 0);
            check("t3_ptick", tick, 0);
            tk();
        end
        pause = 1'b0; start = 1'b1;
        tk();
        start = 1'b0;
        check("t3_resume", running, 1);
        check("t3_r1_tick", tick, 0);
        tk();
        check("t3_r2_tick", tick, 1);
        tk();
        check("t3_count3", {tens, ones}, 8'h03);
        repeat (7) tk();
        check("t3_count4", {tens, ones}, 8'h04);
        check("t3_not_done", done, 0);
        tk();
        check("t3_done", done, 1);
        check("t3_final", {tens, ones}, 8'h05);

        // clear priority and start+pause in RUN
        clear = 1'b1;
        tk();
        clear = 1'b0;
        limit_tens = 4'd9; limit_ones = 4'd9; start = 1'b1;
        tk();
        start = 1'b0;
        repeat (10) tk();
        start = 1'b1; pause = 1'b1; clear = 1'b1;
        check("t4_clr_tick", tick, 0);
        tk();
        clear = 1'b0; start = 1'b0; pause = 1'b0;
        check("t4_clr_count", {tens, ones}, 8'h00);
        check("t4_clr_idle", running, 0);
        tk();
        check("t4_idle_stay", running, 0);
        start = 1'b1;
        tk();
        check("t4_run", running, 1);
        pause = 1'b1;
        tk();
        check("t4_sp_pause", running, 0);
        start = 1'b0; pause = 1'b0; clear = 1'b1;
        tk();
        clear = 1'b0;
        check("t4_pause_clr", {tens, ones}, 8'h00);
        tk();
        check("t4_pause_clr_idle", running, 0);

        // limit 00, then clamped 99
        limit_tens = 4'd0; limit_ones = 4'd0; start = 1'b1;
        tk();
        start = 1'b0;
        check("t5_zero_done", done, 1);
        check("t5_zero_run", running, 0);
        check("t5_zero_tick", tick, 0);
        tk();
        check("t5_zero_pulse", done, 0);
        check("t5_zero_tick2", tick, 0);
        limit_tens = 4'hF; limit_ones = 4'hC; start = 1'b1;
        tk();
        start = 1'b0;
        check("t5_run", running, 1);
        repeat (395) tk();
        check("t5_98", {tens, ones}, 8'h98);
        check("t5_98_done", done, 0);
        check("t5_98_tick", tick, 1);
        tk();
        check("t5_99_done", done, 1);
        check("t5_99", {tens, ones}, 8'h99);

        // start held in DONE restarts immediately
        limit_tens = 4'd0; limit_ones = 4'd3; start = 1'b1;
        tk();
        check("t6_restart", running, 1);
        check("t6_zero", {tens, ones}, 8'h00);
        check("t6_done_low", done, 0);
        repeat (11) tk();
        check("t6_02", {tens, ones}, 8'h02);
        tk();
        check("t6_done", done, 1);
        check("t6_03", {tens, ones}, 8'h03);
        check("t6_stop", running, 0);
        tk();
        check("t6_again", running, 1);
        check("t6_again_zero", {tens, ones}, 8'h00);
        start = 1'b0;

        // async reset mid-run at 37
        clear = 1'b1;
        tk();
        clear = 1'b0;
        limit_tens = 4'd9; limit_ones = 4'd9; start = 1'b1;
        tk();
        start = 1'b0;
        repeat (148) tk();
        check("t1_37", {tens, ones}, 8'h37);
        check("t1_running", running, 1);
        #2 reset = 1'b0;
        #1;
        check("t1_async_count", {tens, ones}, 8'h00);
        check("t1_async_run", running, 0);
        check("t1_async_tick", tick, 0);
        tk();
        check("t1_held", {tens, ones}, 8'h00);
        #3 reset = 1'b1;
        tk();
        check("t1_idle", running, 0);
        check("t1_idle_count", {tens, ones}, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
